// File: rtl/id_ex_decode.sv
// Instruction-decode stage with ID/EX pipeline register feeding the 16-bit ALU.
// Decodes the fetched instruction, reads the register file and registers the EX command.
module id_ex_decode #(
   parameter bit LOAD_USE_STALL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_instr,
   input  logic [15:0] in_pc,
   input  logic        flush,
   output logic [2:0]  rf_raddr_a,
   output logic [2:0]  rf_raddr_b,
   input  logic [15:0] rf_rdata_a,
   input  logic [15:0] rf_rdata_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_com,
   output logic [15:0] out_ina,
   output logic [15:0] out_inb,
   output logic [2:0]  out_rd,
   output logic        out_we,
   output logic        out_mem_rd,
   output logic        out_mem_wr,
   output logic [15:0] out_st_data,
   output logic        out_branch,
   output logic        out_jump,
   output logic [15:0] out_target,
   output logic        out_illegal,
   output logic [15:0] out_pc
);

   typedef enum logic [2:0] {
      ALU_THA = 3'd0,
      ALU_THB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SL  = 3'd4,
      ALU_SR  = 3'd5,
      ALU_ADD = 3'd6,
      ALU_SUB = 3'd7
   } alu_cmd_e;

   logic [3:0]  op;
   logic [2:0]  rd;
   logic [2:0]  rs;
   logic [2:0]  rt;
   logic [2:0]  func;
   logic [5:0]  imm6;
   logic [8:0]  imm9;
   logic [11:0] imm12;
   logic [15:0] sext6;
   logic [15:0] sext12;

   assign op     = in_instr[15:12];
   assign rd     = in_instr[11:9];
   assign rs     = in_instr[8:6];
   assign rt     = in_instr[5:3];
   assign func   = in_instr[2:0];
   assign imm6   = in_instr[5:0];
   assign imm9   = in_instr[8:0];
   assign imm12  = in_instr[11:0];
   assign sext6  = {{10{imm6[5]}}, imm6};
   assign sext12 = {{4{imm12[11]}}, imm12};

   assign rf_raddr_a = rs;

   // Stores and branches read their second operand through the rd field.
   always_comb begin
      rf_raddr_b = 3'd0;
      case (op)
         4'd1:       rf_raddr_b = rt;
         4'd5, 4'd6: rf_raddr_b = rd;
         default:    rf_raddr_b = 3'd0;
      endcase
   end

   alu_cmd_e    com_d;
   logic [15:0] ina_d;
   logic [15:0] inb_d;
   logic        we_d;
   logic        mem_rd_d;
   logic        mem_wr_d;
   logic [15:0] st_data_d;
   logic        branch_d;
   logic        jump_d;
   logic [15:0] target_d;
   logic        illegal_d;
   logic        reads_a;
   logic        reads_b;

   always_comb begin
      com_d     = ALU_THA;
      ina_d     = 16'd0;
      inb_d     = 16'd0;
      we_d      = 1'b0;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      st_data_d = 16'd0;
      branch_d  = 1'b0;
      jump_d    = 1'b0;
      target_d  = 16'd0;
      illegal_d = 1'b0;
      reads_a   = 1'b0;
      reads_b   = 1'b0;
      case (op)
         4'd0: ;
         4'd1: begin
            com_d   = alu_cmd_e'(func);
            ina_d   = rf_rdata_a;
            inb_d   = rf_rdata_b;
            we_d    = 1'b1;
            reads_a = 1'b1;
            reads_b = 1'b1;
         end
         4'd2: begin
            com_d   = ALU_ADD;
            ina_d   = rf_rdata_a;
            inb_d   = sext6;
            we_d    = 1'b1;
            reads_a = 1'b1;
         end
         4'd3: begin
            com_d = ALU_THB;
            inb_d = {7'd0, imm9};
            we_d  = 1'b1;
         end
         4'd4: begin
            com_d    = ALU_ADD;
            ina_d    = rf_rdata_a;
            inb_d    = sext6;
            we_d     = 1'b1;
            mem_rd_d = 1'b1;
            reads_a  = 1'b1;
         end
         4'd5: begin
            com_d     = ALU_ADD;
            ina_d     = rf_rdata_a;
            inb_d     = sext6;
            st_data_d = rf_rdata_b;
            mem_wr_d  = 1'b1;
            reads_a   = 1'b1;
            reads_b   = 1'b1;
         end
         4'd6: begin
            com_d    = ALU_SUB;
            ina_d    = rf_rdata_a;
            inb_d    = rf_rdata_b;
            branch_d = 1'b1;
            target_d = in_pc + sext6;
            reads_a  = 1'b1;
            reads_b  = 1'b1;
         end
         4'd7: begin
            jump_d   = 1'b1;
            target_d = in_pc + sext12;
         end
         default: illegal_d = 1'b1;
      endcase
      if (rd == 3'd0) we_d = 1'b0;
   end

   alu_cmd_e    out_com_q;
   logic        out_valid_q;
   logic [15:0] out_ina_q;
   logic [15:0] out_inb_q;
   logic [2:0]  out_rd_q;
   logic        out_we_q;
   logic        out_mem_rd_q;
   logic        out_mem_wr_q;
   logic [15:0] out_st_data_q;
   logic        out_branch_q;
   logic        out_jump_q;
   logic [15:0] out_target_q;
   logic        out_illegal_q;
   logic [15:0] out_pc_q;
   logic        load_use;
   logic        xfer;

   // A load in EX cannot forward in time, so a dependent instruction waits one cycle.
   assign load_use = LOAD_USE_STALL & out_valid_q & out_mem_rd_q & (out_rd_q != 3'd0) &
                     ((reads_a & (rf_raddr_a == out_rd_q)) | (reads_b & (rf_raddr_b == out_rd_q)));
   assign in_ready = (~out_valid_q | out_ready) & ~load_use & ~flush;
   assign xfer     = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         out_com_q     <= ALU_THA;
         out_ina_q     <= 16'd0;
         out_inb_q     <= 16'd0;
         out_rd_q      <= 3'd0;
         out_we_q      <= 1'b0;
         out_mem_rd_q  <= 1'b0;
         out_mem_wr_q  <= 1'b0;
         out_st_data_q <= 16'd0;
         out_branch_q  <= 1'b0;
         out_jump_q    <= 1'b0;
         out_target_q  <= 16'd0;
         out_illegal_q <= 1'b0;
         out_pc_q      <= 16'd0;
      end else if (flush) begin
         out_valid_q   <= 1'b0;
         out_we_q      <= 1'b0;
         out_mem_rd_q  <= 1'b0;
         out_mem_wr_q  <= 1'b0;
         out_branch_q  <= 1'b0;
         out_jump_q    <= 1'b0;
         out_illegal_q <= 1'b0;
      end else if (xfer) begin
         out_valid_q   <= 1'b1;
         out_com_q     <= com_d;
         out_ina_q     <= ina_d;
         out_inb_q     <= inb_d;
         out_rd_q      <= rd;
         out_we_q      <= we_d;
         out_mem_rd_q  <= mem_rd_d;
         out_mem_wr_q  <= mem_wr_d;
         out_st_data_q <= st_data_d;
         out_branch_q  <= branch_d;
         out_jump_q    <= jump_d;
         out_target_q  <= target_d;
         out_illegal_q <= illegal_d;
         out_pc_q      <= in_pc;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_com     = out_com_q;
   assign out_ina     = out_ina_q;
   assign out_inb     = out_inb_q;
   assign out_rd      = out_rd_q;
   assign out_we      = out_we_q;
   assign out_mem_rd  = out_mem_rd_q;
   assign out_mem_wr  = out_mem_wr_q;
   assign out_st_data = out_st_data_q;
   assign out_branch  = out_branch_q;
   assign out_jump    = out_jump_q;
   assign out_target  = out_target_q;
   assign out_illegal = out_illegal_q;
   assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_id_ex_decode.sv
// Directed bench for id_ex_decode: decode table, handshake, load-use bubble, flush and reset.
// A second instance with the interlock disabled shows the no-bubble behaviour.
module tb_id_ex_decode;

   logic        clk;
   logic        rstN;
   logic        inValid;
   logic [15:0] inInstr;
   logic [15:0] inPc;
   logic        flush;
   logic        outReady;
   logic [15:0] rfRdataA;
   logic [15:0] rfRdataB;

   logic        inReady;
   logic [2:0]  rfRaddrA;
   logic [2:0]  rfRaddrB;
   logic        outValid;
   logic [2:0]  outCom;
   logic [15:0] outIna;
   logic [15:0] outInb;
   logic [2:0]  outRd;
   logic        outWe;
   logic        outMemRd;
   logic        outMemWr;
   logic [15:0] outStData;
   logic        outBranch;
   logic        outJump;
   logic [15:0] outTarget;
   logic        outIllegal;
   logic [15:0] outPc;

   logic        nsInReady;
   logic [2:0]  nsRfRaddrA;
   logic [2:0]  nsRfRaddrB;
   logic        nsOutValid;
   logic [2:0]  nsOutCom;
   logic [15:0] nsOutIna;
   logic [15:0] nsOutInb;
   logic [2:0]  nsOutRd;
   logic        nsOutWe;
   logic        nsOutMemRd;
   logic        nsOutMemWr;
   logic [15:0] nsOutStData;
   logic        nsOutBranch;
   logic        nsOutJump;
   logic [15:0] nsOutTarget;
   logic        nsOutIllegal;
   logic [15:0] nsOutPc;

   int vectorCount = 0;
   int missCount   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed register-file contents; both instances decode the same addresses.
   function automatic logic [15:0] rfValue(input logic [2:0] addr);
      case (addr)
         3'd0:    rfValue = 16'h0000;
         3'd1:    rfValue = 16'h0005;
         3'd2:    rfValue = 16'h0007;
         3'd3:    rfValue = 16'h0030;
         3'd4:    rfValue = 16'h1234;
         3'd5:    rfValue = 16'h00AA;
         3'd6:    rfValue = 16'h8000;
         default: rfValue = 16'h0F0F;
      endcase
   endfunction

   assign rfRdataA = rfValue(rfRaddrA);
   assign rfRdataB = rfValue(rfRaddrB);

   id_ex_decode #(.LOAD_USE_STALL(1'b1)) dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady),
      .in_instr(inInstr), .in_pc(inPc), .flush(flush),
      .rf_raddr_a(rfRaddrA), .rf_raddr_b(rfRaddrB),
      .rf_rdata_a(rfRdataA), .rf_rdata_b(rfRdataB),
      .out_valid(outValid), .out_ready(outReady), .out_com(outCom),
      .out_ina(outIna), .out_inb(outInb), .out_rd(outRd), .out_we(outWe),
      .out_mem_rd(outMemRd), .out_mem_wr(outMemWr), .out_st_data(outStData),
      .out_branch(outBranch), .out_jump(outJump), .out_target(outTarget),
      .out_illegal(outIllegal), .out_pc(outPc)
   );

   id_ex_decode #(.LOAD_USE_STALL(1'b0)) dutNs (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(nsInReady),
      .in_instr(inInstr), .in_pc(inPc), .flush(flush),
      .rf_raddr_a(nsRfRaddrA), .rf_raddr_b(nsRfRaddrB),
      .rf_rdata_a(rfRdataA), .rf_rdata_b(rfRdataB),
      .out_valid(nsOutValid), .out_ready(outReady), .out_com(nsOutCom),
      .out_ina(nsOutIna), .out_inb(nsOutInb), .out_rd(nsOutRd), .out_we(nsOutWe),
      .out_mem_rd(nsOutMemRd), .out_mem_wr(nsOutMemWr), .out_st_data(nsOutStData),
      .out_branch(nsOutBranch), .out_jump(nsOutJump), .out_target(nsOutTarget),
      .out_illegal(nsOutIllegal), .out_pc(nsOutPc)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] pc);
      inInstr = instr;
      inPc    = pc;
      inValid = 1'b1;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN     = 1'b1;
      inValid  = 1'b0;
      inInstr  = 16'h0000;
      inPc     = 16'h0000;
      flush    = 1'b0;
      outReady = 1'b1;
      #3 rstN = 1'b0;
      #1;
      checkOutput("resetValid", {31'd0, outValid}, 32'd0);
      checkOutput("resetCom", {29'd0, outCom}, 32'd0);
      checkOutput("resetInReady", {31'd0, inReady}, 32'd1);
      tick();
      rstN = 1'b1;

      // R-type ADD r3 = r1 + r2
      applyStimulus(16'h1656, 16'h0010);
      checkOutput("rtypeRaddrA", {29'd0, rfRaddrA}, 32'd1);
      checkOutput("rtypeRaddrB", {29'd0, rfRaddrB}, 32'd2);
      checkOutput("rtypeInReady", {31'd0, inReady}, 32'd1);
      tick();
      inValid = 1'b0;
      checkOutput("rtypeValid", {31'd0, outValid}, 32'd1);
      checkOutput("rtypeCom", {29'd0, outCom}, 32'd6);
      checkOutput("rtypeIna", {16'd0, outIna}, 32'h0005);
      checkOutput("rtypeInb", {16'd0, outInb}, 32'h0007);
      checkOutput("rtypeRd", {29'd0, outRd}, 32'd3);
      checkOutput("rtypeWe", {31'd0, outWe}, 32'd1);
      checkOutput("rtypePc", {16'd0, outPc}, 32'h0010);
      tick();
      checkOutput("drainValid", {31'd0, outValid}, 32'd0);

      // ADDI with imm -1, then BEQ whose target wraps below zero
      applyStimulus(16'h247F, 16'h0020);
      tick();
      checkOutput("addiInb", {16'd0, outInb}, 32'hFFFF);
      checkOutput("addiCom", {29'd0, outCom}, 32'd6);
      checkOutput("addiIna", {16'd0, outIna}, 32'h0005);
      checkOutput("addiWe", {31'd0, outWe}, 32'd1);
      applyStimulus(16'h6C7F, 16'h0000);
      checkOutput("beqRaddrB", {29'd0, rfRaddrB}, 32'd6);
      tick();
      inValid = 1'b0;
      checkOutput("beqTarget", {16'd0, outTarget}, 32'hFFFF);
      checkOutput("beqCom", {29'd0, outCom}, 32'd7);
      checkOutput("beqBranch", {31'd0, outBranch}, 32'd1);
      checkOutput("beqWe", {31'd0, outWe}, 32'd0);
      checkOutput("beqInb", {16'd0, outInb}, 32'h8000);

      // Load-use: LD r4, then ADD reading r4
      applyStimulus(16'h4842, 16'h0030);
      tick();
      checkOutput("ldMemRd", {31'd0, outMemRd}, 32'd1);
      checkOutput("ldInb", {16'd0, outInb}, 32'h0002);
      checkOutput("ldRd", {29'd0, outRd}, 32'd4);
      applyStimulus(16'h1B16, 16'h0032);
      checkOutput("luInReady", {31'd0, inReady}, 32'd0);
      checkOutput("luNsInReady", {31'd0, nsInReady}, 32'd1);
      tick();
      checkOutput("luBubble", {31'd0, outValid}, 32'd0);
      checkOutput("luNsValid", {31'd0, nsOutValid}, 32'd1);
      checkOutput("luNsRd", {29'd0, nsOutRd}, 32'd5);
      checkOutput("luReadyAgain", {31'd0, inReady}, 32'd1);
      tick();
      inValid = 1'b0;
      checkOutput("luValid", {31'd0, outValid}, 32'd1);
      checkOutput("luRd", {29'd0, outRd}, 32'd5);
      checkOutput("luIna", {16'd0, outIna}, 32'h1234);
      checkOutput("luInb", {16'd0, outInb}, 32'h0007);

      // Store carries rd register as data
      applyStimulus(16'h5A43, 16'h0040);
      tick();
      checkOutput("stData", {16'd0, outStData}, 32'h00AA);
      checkOutput("stMemWr", {31'd0, outMemWr}, 32'd1);
      checkOutput("stWe", {31'd0, outWe}, 32'd0);
      checkOutput("stInb", {16'd0, outInb}, 32'h0003);

      // LI then backpressure for three cycles, then flush
      applyStimulus(16'h3BFF, 16'h0042);
      tick();
      outReady = 1'b0;
      inInstr  = 16'h2041;
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("bpInReady", {31'd0, inReady}, 32'd0);
         tick();
         checkOutput("bpValid", {31'd0, outValid}, 32'd1);
         checkOutput("bpInb", {16'd0, outInb}, 32'h01FF);
         checkOutput("bpCom", {29'd0, outCom}, 32'd1);
      end
      flush = 1'b1;
      #1;
      checkOutput("flushInReady", {31'd0, inReady}, 32'd0);
      tick();
      flush    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      checkOutput("flushValid", {31'd0, outValid}, 32'd0);
      checkOutput("flushWe", {31'd0, outWe}, 32'd0);

      // Illegal opcode, then ADDI targeting r0
      applyStimulus(16'hF000, 16'h0050);
      tick();
      checkOutput("illIllegal", {31'd0, outIllegal}, 32'd1);
      checkOutput("illWe", {31'd0, outWe}, 32'd0);
      checkOutput("illMemRd", {31'd0, outMemRd}, 32'd0);
      checkOutput("illMemWr", {31'd0, outMemWr}, 32'd0);
      applyStimulus(16'h2041, 16'h0052);
      tick();
      checkOutput("r0We", {31'd0, outWe}, 32'd0);
      checkOutput("r0Inb", {16'd0, outInb}, 32'h0001);
      checkOutput("r0Illegal", {31'd0, outIllegal}, 32'd0);

      // JMP with negative offset, then reset while stalled
      applyStimulus(16'h7800, 16'h0100);
      tick();
      checkOutput("jmpTarget", {16'd0, outTarget}, 32'hF900);
      checkOutput("jmpJump", {31'd0, outJump}, 32'd1);
      outReady = 1'b0;
      tick();
      checkOutput("stallValid", {31'd0, outValid}, 32'd1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("asyncValid", {31'd0, outValid}, 32'd0);
      checkOutput("asyncTarget", {16'd0, outTarget}, 32'd0);
      checkOutput("asyncJump", {31'd0, outJump}, 32'd0);
      checkOutput("asyncPc", {16'd0, outPc}, 32'd0);
      tick();
      rstN     = 1'b1;
      inValid  = 1'b0;
      outReady = 1'b1;
      #1;
      checkOutput("postResetReady", {31'd0, inReady}, 32'd1);
      applyStimulus(16'h1656, 16'h0060);
      tick();
      inValid = 1'b0;
      checkOutput("resumeValid", {31'd0, outValid}, 32'd1);
      checkOutput("resumeIna", {16'd0, outIna}, 32'h0005);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
